jtag_scan_master: RTL and testbench

Host-side JTAG initiator that drives TCK/TMS/TDI towards a TAP and samples TDO, turning single request words into complete TAP walks: test-logic reset, IR scan, DR scan, or run-test/idle clocking. It sits in the SoC (or test harness) as the driving end of the chip's JTAG debug/configuration chain, letting firmware or a testbench reach JTAG configuration registers and the debug AXI scan register without an external probe.

---
 rtl/jtag_scan_master.sv | 226 ++++++++++++++++++++++
 tb/tb_jtag_scan_master.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_scan_master.sv
// JTAG initiator: turns request words into complete TAP walks (TLR, IR scan, DR scan, run-idle).
// Optional JTAG_MASTER_AUTO_RESET_EN: issue a silent TLR walk after reset release.

module jtag_scan_master #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned CLK_DIV = 2,
   localparam int unsigned LEN_W  = $clog2(DATA_W)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [1:0]        req_op_i,
   input  logic [LEN_W-1:0]  req_len_i,
   input  logic [DATA_W-1:0] req_data_i,
   output logic              rsp_valid_o,
   output logic [DATA_W-1:0] rsp_data_o,
   output logic              tck_o,
   output logic              tms_o,
   output logic              tdi_o,
   input  logic              tdo_i
);

   localparam int unsigned CNT_W    = (LEN_W > 3) ? LEN_W : 3;
   localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);

   localparam logic [1:0] OP_TLR = 2'b00;
   localparam logic [1:0] OP_IR  = 2'b01;
   localparam logic [1:0] OP_DR  = 2'b10;
   localparam logic [1:0] OP_RUN = 2'b11;

   typedef enum logic [2:0] {StBoot, StIdle, StPre, StShift, StPost} state_e;

   state_e            state_q, state_d;
   logic [1:0]        op_q, op_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_m1;
   logic [DATA_W-1:0] data_q, data_d;
   logic [DATA_W-1:0] cap_q, cap_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic [7:0]        div_q, div_d;
   logic              tck_q, tck_d;
   logic              tms_q, tms_d;
   logic              tdi_q, tdi_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              quiet_q, quiet_d;
   logic              busy, tick, rise, fall, finish;
   logic [LEN_W-1:0]  bit_idx;

   assign busy    = (state_q == StPre) || (state_q == StShift) || (state_q == StPost);
   assign tick    = (div_q == DIV_LAST);
   assign rise    = busy & tick & ~tck_q;
   assign fall    = busy & tick & tck_q;
   assign cnt_m1  = cnt_q - 1'b1;
   // Shift counter runs n-1..0, so the bit position is its distance from the top.
   assign bit_idx = len_q - cnt_q[LEN_W-1:0];

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      data_d      = data_q;
      cap_d       = cap_q;
      div_d       = div_q;
      tck_d       = tck_q;
      tms_d       = tms_q;
      tdi_d       = tdi_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      quiet_d     = quiet_q;
      finish      = 1'b0;

      if (busy) begin
         div_d = tick ? 8'd0 : div_q + 8'd1;
         if (tick) begin
            tck_d = ~tck_q;
         end
      end

      if (rise && (state_q == StShift)) begin
         cap_d[bit_idx] = tdo_i;
      end

      unique case (state_q)
         StBoot: begin
`ifdef JTAG_MASTER_AUTO_RESET_EN
            state_d = StPre;
            op_d    = OP_TLR;
            cnt_d   = CNT_W'(5);
            cap_d   = '0;
            div_d   = 8'd0;
            tms_d   = 1'b1;
            tdi_d   = 1'b0;
            quiet_d = 1'b1;
`else
            state_d = StIdle;
`endif
         end

         StIdle: begin
            if (req_valid_i) begin
               state_d = StPre;
               op_d    = req_op_i;
               len_d   = req_len_i;
               data_d  = req_data_i;
               cap_d   = '0;
               div_d   = 8'd0;
               tdi_d   = 1'b0;
               quiet_d = 1'b0;
               unique case (req_op_i)
                  OP_TLR: begin cnt_d = CNT_W'(5);         tms_d = 1'b1; end
                  OP_IR:  begin cnt_d = CNT_W'(3);         tms_d = 1'b1; end
                  OP_DR:  begin cnt_d = CNT_W'(2);         tms_d = 1'b1; end
                  OP_RUN: begin cnt_d = CNT_W'(req_len_i); tms_d = 1'b0; end
                  default: ;
               endcase
            end
         end

         // Walk from RTI to Shift-xR, or the whole TLR / run-idle sequence.
         StPre: begin
            if (fall) begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_m1;
                  if (op_q == OP_TLR) begin
                     tms_d = (cnt_m1 != '0);
                  end else if (op_q == OP_RUN) begin
                     tms_d = 1'b0;
                  end else begin
                     tms_d = (cnt_m1 >= CNT_W'(2));
                  end
               end else if ((op_q == OP_TLR) || (op_q == OP_RUN)) begin
                  finish = 1'b1;
               end else begin
                  state_d = StShift;
                  cnt_d   = CNT_W'(len_q);
                  tms_d   = (len_q == '0);
                  tdi_d   = data_q[0];
               end
            end
         end

         StShift: begin
            if (fall) begin
               if (cnt_q != '0) begin
                  cnt_d  = cnt_m1;
                  data_d = data_q >> 1;
                  tdi_d  = data_d[0];
                  tms_d  = (cnt_q == CNT_W'(1));
               end else begin
                  state_d = StPost;
                  cnt_d   = CNT_W'(1);
                  tms_d   = 1'b1;
                  tdi_d   = 1'b0;
               end
            end
         end

         // Exit1 -> Update (TMS 1) -> RTI (TMS 0).
         StPost: begin
            if (fall) begin
               if (cnt_q != '0) begin
                  cnt_d = '0;
                  tms_d = 1'b0;
               end else begin
                  finish = 1'b1;
               end
            end
         end

         default: state_d = StIdle;
      endcase

      if (finish) begin
         state_d     = StIdle;
         tms_d       = 1'b0;
         tdi_d       = 1'b0;
         quiet_d     = 1'b0;
         rsp_valid_d = ~quiet_q;
         if (!quiet_q) begin
            rsp_data_d = cap_q;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StBoot;
         op_q        <= OP_TLR;
         len_q       <= '0;
         cnt_q       <= '0;
         data_q      <= '0;
         cap_q       <= '0;
         div_q       <= 8'd0;
         tck_q       <= 1'b0;
         tms_q       <= 1'b1;
         tdi_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         quiet_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         data_q      <= data_d;
         cap_q       <= cap_d;
         div_q       <= div_d;
         tck_q       <= tck_d;
         tms_q       <= tms_d;
         tdi_q       <= tdi_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         quiet_q     <= quiet_d;
      end
   end

   assign req_ready_o = (state_q == StIdle);
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;
   assign tck_o       = tck_q;
   assign tms_o       = tms_q;
   assign tdi_o       = tdi_q;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Directed bench for jtag_scan_master with a behavioural TAP (16-state controller, DR/IR regs).
// Follows JTAG_MASTER_AUTO_RESET_EN when defined.

module tb_jtag_scan_master;

   localparam int unsigned CLK_DIV = 2;

   typedef enum int {TapTlr, TapRti, TapSelDr, TapCapDr, TapShDr, TapEx1Dr, TapPauDr, TapEx2Dr,
                     TapUpdDr, TapSelIr, TapCapIr, TapShIr, TapEx1Ir, TapPauIr, TapEx2Ir,
                     TapUpdIr} tap_e;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = 2'b00;
   logic [4:0]  req_len = 5'd0;
   logic [31:0] req_data = 32'd0;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        tck, tms, tdi;
   logic        tdo = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   tap_e        tap = TapTlr;
   logic [63:0] sreg = '0;
   int          sl = 1;
   int          dr_len = 1;
   logic [63:0] dr_cap = '0;
   int          tck_cnt = 0, shin_cnt = 0, stray = 0, rsp_cnt = 0;
   logic        tms_log [0:4095];
   logic        shin_log [0:4095];
   int          b_tck, b_sh, b_st, b_rsp;

   always #5 clk = ~clk;

   jtag_scan_master #(.DATA_W(32), .CLK_DIV(CLK_DIV)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
      .req_len_i(req_len), .req_data_i(req_data),
      .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
      .tck_o(tck), .tms_o(tms), .tdi_o(tdi), .tdo_i(tdo)
   );

   function automatic tap_e tap_next(tap_e s, logic t);
      case (s)
         TapTlr:   return t ? TapTlr   : TapRti;
         TapRti:   return t ? TapSelDr : TapRti;
         TapSelDr: return t ? TapSelIr : TapCapDr;
         TapCapDr: return t ? TapEx1Dr : TapShDr;
         TapShDr:  return t ? TapEx1Dr : TapShDr;
         TapEx1Dr: return t ? TapUpdDr : TapPauDr;
         TapPauDr: return t ? TapEx2Dr : TapPauDr;
         TapEx2Dr: return t ? TapUpdDr : TapShDr;
         TapUpdDr: return t ? TapSelDr : TapRti;
         TapSelIr: return t ? TapTlr   : TapCapIr;
         TapCapIr: return t ? TapEx1Ir : TapShIr;
         TapShIr:  return t ? TapEx1Ir : TapShIr;
         TapEx1Ir: return t ? TapUpdIr : TapPauIr;
         TapPauIr: return t ? TapEx2Ir : TapPauIr;
         TapEx2Ir: return t ? TapUpdIr : TapShIr;
         default:  return t ? TapSelDr : TapRti;
      endcase
   endfunction

   always @(posedge tck) begin
      if (tck_cnt < 4096) tms_log[tck_cnt] = tms;
      tck_cnt++;
      if (tap == TapShDr || tap == TapShIr) begin
         if (shin_cnt < 4096) shin_log[shin_cnt] = tdi;
         shin_cnt++;
         sreg = (sreg >> 1) | (64'(tdi) << (sl - 1));
      end else if (tdi) begin
         stray++;
      end
      if (tap == TapCapDr) begin sreg = dr_cap; sl = dr_len; end
      if (tap == TapCapIr) begin sreg = 64'h1;  sl = 5;      end
      tap = tap_next(tap, tms);
   end

   always @(negedge tck) tdo = (tap == TapShDr || tap == TapShIr) ? sreg[0] : 1'b0;

   always @(negedge clk) if (rsp_valid) rsp_cnt++;

   function automatic logic [63:0] tms_since(int base);
      logic [63:0] v = '0;
      for (int k = 0; k < 64 && base + k < tck_cnt; k++) v[k] = tms_log[base + k];
      return v;
   endfunction

   function automatic logic [63:0] shin_since(int base);
      logic [63:0] v = '0;
      for (int k = 0; k < 64 && base + k < shin_cnt; k++) v[k] = shin_log[base + k];
      return v;
   endfunction

   task automatic mark();
      b_tck = tck_cnt; b_sh = shin_cnt; b_st = stray; b_rsp = rsp_cnt;
   endtask

   task automatic send_req(input logic [1:0] op, input logic [4:0] len, input logic [31:0] data,
                           output logic [31:0] rdata, output bit ok);
      int n;
      ok = 1'b0; rdata = '0;
      @(negedge clk);
      n = 0;
      while (!req_ready && n < 500) begin @(negedge clk); n++; end
      if (!req_ready) return;
      mark();
      req_op = op; req_len = len; req_data = data; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; req_op = ~op; req_len = ~len; req_data = ~data;
      n = 0;
      do begin @(negedge clk); n++; end while (!rsp_valid && n < 2000);
      if (rsp_valid) begin rdata = rsp_data; ok = 1'b1; end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      int n;
      repeat (3) @(negedge clk);
      vectors++; if (tck !== 1'b0) begin miscompares++; $display("FAIL reset_tck got %b want 0", tck); end
      vectors++; if (tms !== 1'b1) begin miscompares++; $display("FAIL reset_tms got %b want 1", tms); end
      vectors++; if (tdi !== 1'b0) begin miscompares++; $display("FAIL reset_tdi got %b want 0", tdi); end
      vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b want 0", req_ready); end
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
      vectors++; if (rsp_data !== 32'd0) begin miscompares++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
      mark();
      rst_n = 1'b1;
`ifdef JTAG_MASTER_AUTO_RESET_EN
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!req_ready && n < 200);
      vectors++; if (n != 6 * 2 * CLK_DIV + 1) begin miscompares++; $display("FAIL auto_tlr_ready_delay got %0d want %0d", n, 6 * 2 * CLK_DIV + 1); end
      vectors++; if (tck_cnt - b_tck != 6) begin miscompares++; $display("FAIL auto_tlr_tck got %0d want 6", tck_cnt - b_tck); end
      vectors++; if (tms_since(b_tck) !== 64'h1F) begin miscompares++; $display("FAIL auto_tlr_tms got %h want 1f", tms_since(b_tck)); end
      vectors++; if (rsp_cnt != b_rsp) begin miscompares++; $display("FAIL auto_tlr_rsp got %0d want 0", rsp_cnt - b_rsp); end
      vectors++; if (tap != TapRti) begin miscompares++; $display("FAIL auto_tlr_tap got %0d want %0d", tap, TapRti); end
`else
      #1;
      vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL ready_before_edge got %b want 0", req_ready); end
      @(posedge clk); #1;
      vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_edge got %b want 1", req_ready); end
      vectors++; if (tck_cnt != b_tck) begin miscompares++; $display("FAIL no_auto_tck got %0d want 0", tck_cnt - b_tck); end
`endif
   endtask

   task automatic test_tlr();
      logic [31:0] r; bit ok;
      send_req(2'b00, 5'd0, 32'hFFFF_FFFF, r, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL tlr_timeout got none want rsp"); end
      vectors++; if (r !== 32'd0) begin miscompares++; $display("FAIL tlr_rsp got %h want 0", r); end
      vectors++; if (tck_cnt - b_tck != 6) begin miscompares++; $display("FAIL tlr_tck got %0d want 6", tck_cnt - b_tck); end
      vectors++; if (tms_since(b_tck) !== 64'h1F) begin miscompares++; $display("FAIL tlr_tms got %h want 1f", tms_since(b_tck)); end
      vectors++; if (tap != TapRti) begin miscompares++; $display("FAIL tlr_tap got %0d want %0d", tap, TapRti); end
      vectors++; if (tms !== 1'b0) begin miscompares++; $display("FAIL tlr_idle_tms got %b want 0", tms); end
   endtask

   task automatic test_dr_pattern();
      logic [31:0] r; bit ok;
      dr_len = 8; dr_cap = 64'h3C;
      send_req(2'b10, 5'd7, 32'h0000_00A5, r, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL dr_timeout got none want rsp"); end
      vectors++; if (r !== 32'h0000_003C) begin miscompares++; $display("FAIL dr_rsp got %h want 3c", r); end
      vectors++; if (tck_cnt - b_tck != 13) begin miscompares++; $display("FAIL dr_tck got %0d want 13", tck_cnt - b_tck); end
      vectors++; if (tms_since(b_tck) !== 64'hC01) begin miscompares++; $display("FAIL dr_tms got %h want c01", tms_since(b_tck)); end
      vectors++; if (shin_cnt - b_sh != 8) begin miscompares++; $display("FAIL dr_shift_cnt got %0d want 8", shin_cnt - b_sh); end
      vectors++; if (shin_since(b_sh) !== 64'hA5) begin miscompares++; $display("FAIL dr_tdi got %h want a5", shin_since(b_sh)); end
      vectors++; if (stray != b_st) begin miscompares++; $display("FAIL dr_stray_tdi got %0d want 0", stray - b_st); end
      vectors++; if (rsp_cnt - b_rsp != 1) begin miscompares++; $display("FAIL dr_pulses got %0d want 1", rsp_cnt - b_rsp); end
      vectors++; if (tap != TapRti) begin miscompares++; $display("FAIL dr_tap got %0d want %0d", tap, TapRti); end
      vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL dr_ready got %b want 1", req_ready); end
   endtask

   task automatic test_ir();
      logic [31:0] r; bit ok;
      send_req(2'b01, 5'd4, 32'h0000_0001, r, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL ir_timeout got none want rsp"); end
      vectors++; if (r !== 32'h0000_0001) begin miscompares++; $display("FAIL ir_rsp got %h want 1", r); end
      vectors++; if (tck_cnt - b_tck != 11) begin miscompares++; $display("FAIL ir_tck got %0d want 11", tck_cnt - b_tck); end
      vectors++; if (tms_since(b_tck) !== 64'h303) begin miscompares++; $display("FAIL ir_tms got %h want 303", tms_since(b_tck)); end
      vectors++; if (shin_cnt - b_sh != 5) begin miscompares++; $display("FAIL ir_shift_cnt got %0d want 5", shin_cnt - b_sh); end
      vectors++; if (shin_since(b_sh) !== 64'h01) begin miscompares++; $display("FAIL ir_tdi got %h want 01", shin_since(b_sh)); end
      vectors++; if (rsp_cnt - b_rsp != 1) begin miscompares++; $display("FAIL ir_pulses got %0d want 1", rsp_cnt - b_rsp); end
      vectors++; if (tap != TapRti) begin miscompares++; $display("FAIL ir_tap got %0d want %0d", tap, TapRti); end
   endtask

   task automatic test_bypass();
      logic [31:0] r; bit ok;
      dr_len = 1; dr_cap = 64'h0;
      send_req(2'b10, 5'd31, 32'hDEAD_BEEF, r, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL byp_timeout got none want rsp"); end
      vectors++; if (r !== 32'hBD5B_7DDE) begin miscompares++; $display("FAIL byp_rsp got %h want bd5b7dde", r); end
      vectors++; if (tck_cnt - b_tck != 37) begin miscompares++; $display("FAIL byp_tck got %0d want 37", tck_cnt - b_tck); end
      vectors++; if (tms_since(b_tck) !== 64'h0000_000C_0000_0001) begin miscompares++; $display("FAIL byp_tms got %h want c00000001", tms_since(b_tck)); end
      vectors++; if (shin_since(b_sh) !== 64'hDEAD_BEEF) begin miscompares++; $display("FAIL byp_tdi got %h want deadbeef", shin_since(b_sh)); end
   endtask

   task automatic test_len1();
      logic [31:0] r; bit ok;
      dr_len = 1; dr_cap = 64'h1;
      send_req(2'b10, 5'd0, 32'h0000_0000, r, ok);
      vectors++; if (r !== 32'h1 || !ok) begin miscompares++; $display("FAIL len1_rsp got %h want 1", r); end
      vectors++; if (tck_cnt - b_tck != 6) begin miscompares++; $display("FAIL len1_tck got %0d want 6", tck_cnt - b_tck); end
      vectors++; if (tms_since(b_tck) !== 64'h19) begin miscompares++; $display("FAIL len1_tms got %h want 19", tms_since(b_tck)); end
   endtask

   task automatic test_run_idle();
      logic [31:0] r; bit ok;
      send_req(2'b11, 5'd4, 32'hFFFF_FFFF, r, ok);
      vectors++; if (r !== 32'd0 || !ok) begin miscompares++; $display("FAIL run_rsp got %h want 0", r); end
      vectors++; if (tck_cnt - b_tck != 5) begin miscompares++; $display("FAIL run_tck got %0d want 5", tck_cnt - b_tck); end
      vectors++; if (tms_since(b_tck) !== 64'h0) begin miscompares++; $display("FAIL run_tms got %h want 0", tms_since(b_tck)); end
      vectors++; if (stray != b_st) begin miscompares++; $display("FAIL run_stray_tdi got %0d want 0", stray - b_st); end
      vectors++; if (tap != TapRti) begin miscompares++; $display("FAIL run_tap got %0d want %0d", tap, TapRti); end
   endtask

   task automatic test_back_to_back();
      int n;
      @(negedge clk);
      n = 0;
      while (!req_ready && n < 500) begin @(negedge clk); n++; end
      mark();
      req_op = 2'b11; req_len = 5'd1; req_data = 32'd0; req_valid = 1'b1;
      @(posedge clk); #1;
      req_op = 2'b00; req_len = 5'd0;
      n = 0;
      do begin @(negedge clk); n++; end while (!rsp_valid && n < 500);
      vectors++; if (!(rsp_valid && req_ready)) begin miscompares++; $display("FAIL b2b_ready_in_rsp got %b want 1", req_ready); end
      n = 0;
      do begin @(posedge clk); #1; n++; if (n == 1) req_valid = 1'b0; end while (!tck && n < 20);
      vectors++; if (n != CLK_DIV + 1) begin miscompares++; $display("FAIL b2b_tck_rise got %0d want %0d", n, CLK_DIV + 1); end
      n = 0;
      do begin @(negedge clk); n++; end while (!rsp_valid && n < 500);
      repeat (3) @(negedge clk);
      vectors++; if (rsp_cnt - b_rsp != 2) begin miscompares++; $display("FAIL b2b_pulses got %0d want 2", rsp_cnt - b_rsp); end
      vectors++; if (tms_since(b_tck) !== 64'h7C) begin miscompares++; $display("FAIL b2b_tms got %h want 7c", tms_since(b_tck)); end
      vectors++; if (tap != TapRti) begin miscompares++; $display("FAIL b2b_tap got %0d want %0d", tap, TapRti); end
   endtask

   task automatic test_reset_mid_op();
      int n;
      logic [31:0] r; bit ok;
      dr_len = 8; dr_cap = 64'h3C;
      @(negedge clk);
      n = 0;
      while (!req_ready && n < 500) begin @(negedge clk); n++; end
      mark();
      req_op = 2'b10; req_len = 5'd7; req_data = 32'hA5; req_valid = 1'b1;
      @(posedge clk); #1; req_valid = 1'b0;
      n = 0;
      while (shin_cnt - b_sh < 3 && n < 500) begin @(negedge clk); n++; end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      vectors++; if (tck !== 1'b0) begin miscompares++; $display("FAIL midrst_tck got %b want 0", tck); end
      vectors++; if (tms !== 1'b1) begin miscompares++; $display("FAIL midrst_tms got %b want 1", tms); end
      vectors++; if (tdi !== 1'b0) begin miscompares++; $display("FAIL midrst_tdi got %b want 0", tdi); end
      vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_ready got %b want 0", req_ready); end
      vectors++; if (rsp_data !== 32'd0) begin miscompares++; $display("FAIL midrst_rsp_data got %h want 0", rsp_data); end
      mark();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      vectors++; if (rsp_cnt != b_rsp) begin miscompares++; $display("FAIL midrst_pulses got %0d want 0", rsp_cnt - b_rsp); end
      vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready_after got %b want 1", req_ready); end
`ifdef JTAG_MASTER_AUTO_RESET_EN
      vectors++; if (tms_since(b_tck) !== 64'h1F || tck_cnt - b_tck != 6) begin miscompares++; $display("FAIL midrst_tlr_replay got %h want 1f", tms_since(b_tck)); end
`else
      vectors++; if (tck_cnt != b_tck) begin miscompares++; $display("FAIL midrst_idle_tck got %0d want 0", tck_cnt - b_tck); end
      send_req(2'b00, 5'd0, 32'd0, r, ok);
      vectors++; if (!ok || r !== 32'd0) begin miscompares++; $display("FAIL midrst_tlr got %h want 0", r); end
`endif
      vectors++; if (tap != TapRti) begin miscompares++; $display("FAIL midrst_tap got %0d want %0d", tap, TapRti); end
   endtask

   initial begin
      test_reset();
      test_tlr();
      test_dr_pattern();
      test_ir();
      test_bypass();
      test_len1();
      test_run_idle();
      test_back_to_back();
      test_dr_pattern();
      test_reset_mid_op();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
